// File: rtl/vn_em_ctrl_pkg.sv
// Shared definitions for the variable-node edge-memory controller.
package vn_em_ctrl_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned SEL_W  = 3;

  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // One Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  // Fold a 3-bit random value into the EM address range 0..n-1 (n >= 4).
  function automatic logic [SEL_W-1:0] sel_map(input logic [SEL_W-1:0] r,
                                               input int unsigned    n);
    if (32'(r) < n) return r;
    else            return r - SEL_W'(n);
  endfunction

endpackage

// File: rtl/vn_em_ctrl_lfsr8.sv
// Seeded, enable-gated 8-bit Fibonacci LFSR shared by variable-node blocks.
module lfsr8
  import vn_em_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // Advance only when requested; otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) lfsr_d = lfsr_step(lfsr_q);
  end

  // State register with synchronous seed load.
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/vn_em_ctrl.sv
// Edge-memory controller for a stochastic LDPC variable node: fills the EM
// with channel bits, then forwards agreeing bits or replays a random EM bit.
module vn_em_ctrl
  import vn_em_ctrl_pkg::*;
#(
  parameter int unsigned       N    = 8,
  parameter int unsigned       DI   = 3,
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             EN,
  input  logic             CH,
  input  logic [DI-1:0]    IN,
  input  logic             EM_OUT,
  output logic             TRIG,
  output logic             EM_IN,
  output logic [SEL_W-1:0] SEL,
  output logic             OUT,
  output logic             READY
);

  localparam int unsigned CNT_W = $clog2(N + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              em_in_q, em_in_d;
  logic              ready_q, ready_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              pulse_q, pulse_d;
  logic              tog_q, tog_d;
  logic              tog_n_q;
  logic              lfsr_adv;
  logic              regular;
  logic [LFSR_W-1:0] lfsr_val;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk     (CLK),
    .rst_n   (RESET),
    .adv_i   (lfsr_adv),
    .state_o (lfsr_val)
  );

  // Regular state: channel bit and every incoming check bit agree.
  always_comb begin
    regular = (CH & (&IN)) | (~CH & ~(|IN));
  end

  // Next-state and output decisions for IDLE / FILL / RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    em_in_d  = em_in_q;
    pulse_d  = 1'b0;
    lfsr_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        if (EN) begin
          em_in_d  = CH;
          out_d    = CH;
          pulse_d  = 1'b1;
          lfsr_adv = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(N)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (EN) begin
          lfsr_adv = 1'b1;
          if (regular) begin
            out_d   = CH;
            em_in_d = CH;
            pulse_d = 1'b1;
          end else begin
            out_d = EM_OUT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tog_d   = tog_q ^ pulse_d;
    ready_d = (state_d == ST_RUN);
    sel_d   = lfsr_adv ? sel_map(lfsr_step(lfsr_val)[SEL_W-1:0], N) : sel_q;
  end

  // Main register bank with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      em_in_q <= 1'b0;
      ready_q <= 1'b0;
      sel_q   <= sel_map(SEED[SEL_W-1:0], N);
      pulse_q <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      em_in_q <= em_in_d;
      ready_q <= ready_d;
      sel_q   <= sel_d;
      pulse_q <= pulse_d;
      tog_q   <= tog_d;
    end
  end

  // Falling-edge copy of the toggle; its lag closes each TRIG pulse mid-cycle
  // so back-to-back shifts still present a falling edge to the EM.
  always_ff @(negedge CLK) begin
    tog_n_q <= tog_q;
  end

  assign TRIG  = pulse_q & (tog_q ^ tog_n_q);
  assign EM_IN = em_in_q;
  assign SEL   = sel_q;
  assign OUT   = out_q;
  assign READY = ready_q;

endmodule

// File: tb/tb_vn_em_ctrl.sv
// Self-checking bench for vn_em_ctrl with a behavioural EM and reference model.
module tb_vn_em_ctrl;

  localparam int unsigned N    = 8;
  localparam int unsigned N5   = 5;
  localparam int unsigned DI   = 3;
  localparam logic [7:0]  SEED = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n, start, en, ch;
  logic [DI-1:0] in_bits;
  logic          em_out;
  logic          trig, em_in, out, ready;
  logic [2:0]    sel;
  logic          trig5, em_in5, out5, ready5;
  logic [2:0]    sel5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vn_em_ctrl #(.N(N), .DI(DI), .SEED(SEED)) dut (
    .CLK(clk), .RESET(rst_n), .START(start), .EN(en), .CH(ch), .IN(in_bits),
    .EM_OUT(em_out), .TRIG(trig), .EM_IN(em_in), .SEL(sel), .OUT(out), .READY(ready)
  );

  vn_em_ctrl #(.N(N5), .DI(DI), .SEED(SEED)) dut5 (
    .CLK(clk), .RESET(rst_n), .START(start), .EN(en), .CH(ch), .IN(in_bits),
    .EM_OUT(1'b0), .TRIG(trig5), .EM_IN(em_in5), .SEL(sel5), .OUT(out5), .READY(ready5)
  );

  // Behavioural edge memory: shifts on TRIG falling edge, newest bit at index 0.
  logic [7:0] em_env = 8'h00;
  always @(negedge trig) begin
    if (rst_n === 1'b1) em_env <= {em_env[6:0], em_in};
  end
  always_comb em_out = em_env[sel];

  // Reference model state
  typedef enum {M_IDLE, M_FILL, M_RUN} mode_t;
  mode_t      m_mode;
  logic [7:0] m_lfsr;
  bit         m_out, m_em_in, m_trig;
  int         m_fill;
  bit         exp_em[$];
  int         trig_count;

  function automatic logic [7:0] ref_next(input logic [7:0] v);
    int fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return 8'((v * 2) | fb);
  endfunction

  function automatic logic [2:0] ref_sel(input logic [7:0] v, input int n);
    int r;
    r = v % 8;
    if (r >= n) r = r - n;
    return 3'(r);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_lfsr  = SEED;
    m_out   = 1'b0;
    m_em_in = 1'b0;
    m_trig  = 1'b0;
    m_fill  = 0;
  endtask

  task automatic model_shift(input bit c);
    m_em_in = c;
    m_out   = c;
    m_trig  = 1'b1;
    exp_em.push_front(c);
    if (exp_em.size() > N) void'(exp_em.pop_back());
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic cyc(input bit r, input bit s, input bit e, input bit c, input logic [2:0] i);
    bit         regular, hold_bit, rdy5;
    logic [2:0] s_before;
    rst_n = r; start = s; en = e; ch = c; in_bits = i;
    s_before = ref_sel(m_lfsr, N);
    hold_bit = (exp_em.size() > int'(s_before)) ? exp_em[s_before] : 1'b0;
    regular  = (c == 1'b1 && i == 3'b111) || (c == 1'b0 && i == 3'b000);
    @(posedge clk); #1;
    m_trig = 1'b0;
    if (!r) model_reset();
    else begin
      case (m_mode)
        M_IDLE: if (s) begin m_mode = M_FILL; m_fill = 0; end
        M_FILL: if (e) begin
          model_shift(c);
          m_fill++;
          m_lfsr = ref_next(m_lfsr);
          if (m_fill == N) m_mode = M_RUN;
        end
        M_RUN: if (e) begin
          if (regular) model_shift(c);
          else         m_out = hold_bit;
          m_lfsr = ref_next(m_lfsr);
        end
        default: ;
      endcase
    end
    chk("OUT",   out,   m_out);
    chk("EM_IN", em_in, m_em_in);
    chk("TRIG",  trig,  m_trig);
    chk("READY", ready, m_mode == M_RUN);
    chk("SEL",   sel,   ref_sel(m_lfsr, N));
    chk("SEL_LT_N", sel < 3'(N - 1) || sel == 3'(N - 1), 1'b1);
    chk("SEL5",  sel5,  ref_sel(m_lfsr, N5));
    rdy5 = (m_mode == M_RUN) || (m_mode == M_FILL && m_fill >= N5);
    chk("READY5", ready5, rdy5);
    if (m_mode == M_FILL && m_fill >= 1 && m_fill <= N5) begin
      chk("OUT5",   out5,   m_out);
      chk("EM_IN5", em_in5, m_em_in);
      chk("TRIG5",  trig5,  m_trig);
    end
    if (trig === 1'b1) trig_count++;
    if (m_trig) begin
      @(negedge clk); #1;
      chk("TRIG_FALL", trig, 1'b0);
    end
  endtask

  initial begin
    bit         fill_seq[8];
    bit         c;
    logic [2:0] i;
    fill_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    model_reset();
    rst_n = 1'b0; start = 1'b0; en = 1'b0; ch = 1'b0; in_bits = '0;

    // Reset held two cycles, then idle with EN but no START
    cyc(0, 0, 0, 0, 3'b000);
    cyc(0, 0, 1, 1, 3'b111);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 1, 3'b111);
    chk("IDLE_SEL_SEED", sel, 3'd5);

    // Fill with a fixed channel sequence
    cyc(1, 1, 1, 0, 3'b000);
    trig_count = 0;
    for (int k = 0; k < 8; k++) cyc(1, 0, 1, fill_seq[k], 3'($urandom_range(0, 7)));
    chk("FILL_TRIGS", 8'(trig_count), 8'd8);
    chk("FILL_READY", ready, 1'b1);
    chk("FILL_EM", em_env, 8'b1011_0010);

    // Regular state, back-to-back, then hold
    cyc(1, 0, 1, 1, 3'b111);
    cyc(1, 0, 1, 0, 3'b000);
    cyc(1, 0, 1, 1, 3'b111);
    cyc(1, 0, 1, 1, 3'b101);
    cyc(1, 0, 0, 1, 3'b111);
    cyc(1, 0, 1, 1, 3'b101);

    // Randomized run including EN gaps and ignored START pulses
    for (int k = 0; k < 300; k++) begin
      c = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) i = c ? 3'b111 : 3'b000;
      else                           i = 3'($urandom_range(0, 7));
      cyc(1, $urandom_range(0, 19) == 0, $urandom_range(0, 9) != 0, c, i);
    end

    // Reset asserted during a TRIG-high cycle in FILL
    cyc(0, 0, 0, 0, 3'b000);
    cyc(1, 1, 1, 0, 3'b000);
    cyc(1, 0, 1, 1, 3'b010);
    cyc(1, 0, 1, 0, 3'b011);
    chk("PRE_RST_TRIG", trig, 1'b0);
    cyc(0, 0, 1, 1, 3'b111);
    chk("RST_TRIG", trig, 1'b0);
    trig_count = 0;
    for (int k = 0; k < 5; k++) cyc(1, 0, 1, 1, 3'b111);
    chk("POST_RST_SHIFTS", 8'(trig_count), 8'd0);
    chk("POST_RST_SEL", sel, 3'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vn_em_ctrl.md
# vn_em_ctrl

Edge-memory controller for a stochastic LDPC variable node, and the write side of the N-bit edge memory (EM). Each decoding cycle it checks the channel bit and the incoming check-node bits against each other. When they all agree (regular state) it forwards the common value and shifts it into the EM. When they disagree (hold state) it outputs a bit read back from a pseudo-random EM address. It also pre-fills the EM with channel bits after reset and generates the EM's shift strobe and read address.

## Interface
- N, 8, EM depth in bits; legal range 4..8
- DI, 3, number of incoming check-to-variable bits (edge under service excluded); ≥1
- SEED, 8'hA5, LFSR reset value; must be nonzero
- CLK  input  1  system clock, rising-edge
- RESET  input  1  synchronous reset, active-low
- START  input  1  one-cycle pulse that begins EM fill; ignored outside IDLE
- EN  input  1  decoding-cycle enable; one stochastic bit per EN cycle
- CH  input  1  channel stochastic bit
- IN  input  DI  incoming check-node bits
- EM_OUT  input  1  EM read data at current SEL
- TRIG  output  1  EM shift strobe; EM captures on TRIG falling edge
- EM_IN  output  1  bit presented to EM shift input
- SEL  output  3  EM read address, always < N
- OUT  output  1  edge output bit
- READY  output  1  high in RUN state

## Operation
- States: IDLE, FILL, RUN.
- IDLE
  - Reached on reset.
  - On START=1, go to FILL and clear the fill counter.
- FILL
  - Every EN=1 cycle: EM_IN←CH, TRIG pulses, OUT←CH, fill counter +1.
  - When the count reaches N, go to RUN. Exactly N shifts occur in FILL.
- RUN, each EN=1 cycle:
  - Regular state, i.e. CH and all IN bits are equal to value v: OUT←v, EM_IN←v, TRIG pulses.
  - Hold state, i.e. any disagreement: OUT←EM_OUT, no TRIG.
- LFSR
  - 8 bits, Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts left, feedback into bit 0.
  - Advances on every EN=1 cycle in FILL and RUN; frozen in IDLE and when EN=0.
- SEL mapping: r = lfsr[2:0]; SEL = r if r<N, else r−N (always <N because N≥4).
- EN=0: no state, counter, LFSR or output change; TRIG stays low.
- START while in FILL or RUN: ignored.
- RESET=0 wins over all other inputs, including mid-FILL and mid-TRIG.

## Timing
- All outputs are registered; one-cycle latency from an EN cycle's inputs to OUT and EM_IN.
- TRIG is high for exactly one CLK cycle, in the cycle after the qualifying EN cycle.
  - EM_IN is already valid when TRIG rises and stays stable until after TRIG falls.
  - The EM shift therefore completes two edges after the decision.
- Back-to-back regular EN cycles give TRIG high on consecutive cycles. Each is a separate pulse: TRIG is forced low for a half-cycle-equivalent by gating with a registered toggle, so every shift sees a falling edge.
- In a hold cycle, EM_OUT is sampled combinationally at the SEL in effect during that EN cycle. The LFSR advances at the same edge, so a new SEL applies to the next EN cycle.
- Reset values:
  - state=IDLE, fill counter=0, lfsr=SEED.
  - TRIG=0, EM_IN=0, OUT=0, READY=0.
  - SEL = map(SEED[2:0]).
- READY rises in the cycle after the N-th FILL shift.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, FILL=2'd1, RUN=2'd2),
  - the LFSR width and tap constant,
  - the SEL mapping function.
- Natural sub-module: `lfsr8`, a seeded, enable-gated 8-bit LFSR reused by other variable-node blocks.
- The EM itself is instantiated outside; this block only drives TRIG, EM_IN and SEL and reads EM_OUT.

## Test plan
- Reset/idle:
  - Stimulus: RESET=0 for 2 cycles, then release with SEED=8'hA5.
  - Required: OUT=0, TRIG=0, READY=0, SEL=5.
  - Required with EN=1 but no START: lfsr stays 8'hA5.
- Fill, N=8:
  - Stimulus: START, then 8 EN cycles with CH=1,0,1,1,0,0,1,0.
  - Required: exactly 8 TRIG pulses, EM_IN matching that sequence, READY high on the following cycle.
- Regular state:
  - Stimulus: in RUN, CH=1, IN=3'b111.
  - Required: OUT=1 and one TRIG pulse with EM_IN=1.
  - Stimulus: CH=0, IN=3'b000.
  - Required: OUT=0, TRIG pulse.
- Hold state:
  - Stimulus: CH=1, IN=3'b101, model EM returns bit[SEL].
  - Required: no TRIG; OUT equals the modeled EM bit at the pre-advance SEL.
  - Required over 255 EN cycles: SEL sequence matches the reference LFSR and is always <N.
- N=5 mapping: LFSR states with r=5,6,7 yield SEL=0,1,2.
- Reset mid-operation:
  - Stimulus: RESET=0 asserted during a TRIG-high cycle in FILL.
  - Required: TRIG=0 the next cycle and state returns to IDLE.
  - Stimulus: EN=1 with no START.
  - Required: no further shifts.
